// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - eBPF ALU operand preparation stage with 2-entry skid buffer (optional forwarding: ALU_OPERAND_FWD_EN)
module alu_operand_stage #(
    parameter int DW    = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef ALU_OPERAND_FWD_EN
    input  logic             wb_valid,
    input  logic [3:0]       wb_reg,
    input  logic [DW-1:0]    wb_data,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_opcode,
    input  logic [3:0]       in_dst_reg,
    input  logic [3:0]       in_src_reg,
    input  logic [DW-1:0]    in_dst_val,
    input  logic [DW-1:0]    in_src_val,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_a,
    output logic [DW-1:0]    out_b,
    output logic [3:0]       out_op,
    output logic             out_alu64,
    output logic [3:0]       out_dst_reg,
    output logic [CNT_W-1:0] drop_count
);

    // Bundle layout: {a, b, op, alu64, dst_reg}
    localparam int BW = 2 * DW + 9;

    logic          is_alu64;
    logic          is_alu;
    logic          accept;
    logic          in_xfer;
    logic          out_xfer;
    logic [DW-1:0] a_fwd;
    logic [DW-1:0] b_reg;
    logic [DW-1:0] b_sel;
    logic [DW-1:0] a_new;
    logic [DW-1:0] b_new;
    logic [BW-1:0] new_bundle;
    logic [BW-1:0] main_bundle;
    logic [BW-1:0] skid_bundle;
    logic          main_valid;
    logic          skid_valid;
    logic          skid_valid_nxt;

    assign is_alu64 = (in_opcode[2:0] == 3'h7);
    assign is_alu   = is_alu64 || (in_opcode[2:0] == 3'h4);
    assign in_xfer  = in_valid && in_ready;
    assign accept   = in_xfer && is_alu;
    assign out_xfer = main_valid && out_ready;

`ifndef ALU_OPERAND_FWD_EN
    // The source index only matters when forwarding compares against it.
    logic unused_src_reg;
    assign unused_src_reg = ^in_src_reg;
`endif

    // Operand selection: optional write-back forwarding, then B source, then 32-bit masking.
    always_comb begin
        a_fwd = in_dst_val;
        b_reg = in_src_val;
`ifdef ALU_OPERAND_FWD_EN
        if (wb_valid && (wb_reg == in_dst_reg)) begin
            a_fwd = wb_data;
        end
        if (wb_valid && (wb_reg == in_src_reg)) begin
            b_reg = wb_data;
        end
`endif
        b_sel = in_opcode[3] ? b_reg : {{(DW-32){in_imm[31]}}, in_imm};
        if (is_alu64) begin
            a_new = a_fwd;
            b_new = b_sel;
        end else begin
            a_new = {{(DW-32){1'b0}}, a_fwd[31:0]};
            b_new = {{(DW-32){1'b0}}, b_sel[31:0]};
        end
        new_bundle = {a_new, b_new, in_opcode[7:4], is_alu64, in_dst_reg};
    end

    // Skid occupancy after this edge; a valid skid entry always implies a valid main entry.
    always_comb begin
        skid_valid_nxt = (skid_valid && !out_xfer) ||
                         (accept && main_valid && !out_xfer);
    end

    // Main/skid registers, registered ready and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid  <= 1'b0;
            skid_valid  <= 1'b0;
            main_bundle <= '0;
            skid_bundle <= '0;
            in_ready    <= 1'b1;
            drop_count  <= '0;
        end else begin
            if (!main_valid || out_xfer) begin
                if (skid_valid) begin
                    main_bundle <= skid_bundle;
                    main_valid  <= 1'b1;
                    skid_valid  <= 1'b0;
                end else if (accept) begin
                    main_bundle <= new_bundle;
                    main_valid  <= 1'b1;
                end else begin
                    main_valid  <= 1'b0;
                end
            end else if (accept) begin
                skid_bundle <= new_bundle;
                skid_valid  <= 1'b1;
            end
            in_ready <= !skid_valid_nxt;
            if (in_xfer && !is_alu && (drop_count != {CNT_W{1'b1}})) begin
                drop_count <= drop_count + CNT_W'(1);
            end
        end
    end

    assign out_valid = main_valid;
    assign {out_a, out_b, out_op, out_alu64, out_dst_reg} = main_bundle;

endmodule
